// File: rtl/display_share_arbiter_pkg.sv
// Shared constants and state type for the display share arbiter slice.
package display_pkg;
    localparam int DISP_W           = 16;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_DWELL_CYCLES = 100000000;
    localparam int DEF_CNT_W        = 27;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;
endpackage

// File: rtl/display_share_arbiter_if.sv
// Requester-side bundle of the display share arbiter: level requests, values,
// one-hot ack pulses and the shared display outputs.
interface display_share_arbiter_if #(
    parameter int NUM_REQ = display_pkg::DEF_NUM_REQ,
    parameter int OWN_W   = $clog2(NUM_REQ)
);
    // Handshake: req[i] is a level held until ack[i] pulses for one cycle; the
    // value on req_data slice i is taken only in that capture cycle, and
    // dropping req[i] before ack withdraws the request.
    logic [NUM_REQ-1:0]                   req;
    logic [display_pkg::DISP_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]                   ack;
    logic [display_pkg::DISP_W-1:0]       disp_value;
    logic [OWN_W-1:0]                     disp_owner;
    logic                                 busy;
    display_pkg::state_t                  dbg_state;

    modport master (
        output req, req_data,
        input  ack, disp_value, disp_owner, busy, dbg_state
    );

    modport slave (
        input  req, req_data,
        output ack, disp_value, disp_owner, busy, dbg_state
    );
endinterface

// File: rtl/display_rr_pick.sv
// Combinational round-robin search: first set request at or after i_rr_ptr.
module display_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OWN_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [OWN_W-1:0]   i_rr_ptr,
    output logic               o_found,
    output logic [OWN_W-1:0]   o_grant
);
    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        o_found = 1'b0;
        o_grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int w_idx;
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_grant = OWN_W'(w_idx);
            end
        end
    end
endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin arbiter sharing one four-digit seven-segment display; a granted
// value stays on the display for exactly DWELL_CYCLES clocks.
module display_share_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int OWN_W        = $clog2(NUM_REQ)
) (
    input logic                   clk,
    input logic                   rst,
    display_share_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NUM_REQ - 1);

    state_t               r_state;
    logic [OWN_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]     r_dwell_cnt;
    logic [DISP_W-1:0]    r_disp_value;
    logic [OWN_W-1:0]     r_disp_owner;
    logic [NUM_REQ-1:0]   r_ack;

    state_t               w_next_state;
    logic [OWN_W-1:0]     w_next_rr_ptr;
    logic [CNT_W-1:0]     w_next_dwell_cnt;
    logic [DISP_W-1:0]    w_next_disp_value;
    logic [OWN_W-1:0]     w_next_disp_owner;
    logic [NUM_REQ-1:0]   w_next_ack;
    logic                 w_capture;
    logic                 w_found;
    logic [OWN_W-1:0]     w_grant;

    display_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWN_W   (OWN_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_dwell_cnt  <= '0;
            r_disp_value <= '0;
            r_disp_owner <= '0;
            r_ack        <= '0;
        end else begin
            r_state      <= w_next_state;
            r_rr_ptr     <= w_next_rr_ptr;
            r_dwell_cnt  <= w_next_dwell_cnt;
            r_disp_value <= w_next_disp_value;
            r_disp_owner <= w_next_disp_owner;
            r_ack        <= w_next_ack;
        end
    end

    // Arbitration is only open in IDLE or on the last count of a dwell.
    always_comb begin
        w_next_state      = r_state;
        w_next_rr_ptr     = r_rr_ptr;
        w_next_dwell_cnt  = r_dwell_cnt;
        w_next_disp_value = r_disp_value;
        w_next_disp_owner = r_disp_owner;
        w_next_ack        = '0;
        w_capture         = 1'b0;

        case (r_state)
            IDLE: begin
                w_capture = w_found;
            end
            SHOW: begin
                if (r_dwell_cnt == LAST_CNT) begin
                    if (w_found) begin
                        w_capture = 1'b1;
                    end else begin
                        w_next_state     = IDLE;
                        w_next_dwell_cnt = '0;
                    end
                end else begin
                    w_next_dwell_cnt = r_dwell_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (w_capture) begin
            w_next_state      = SHOW;
            w_next_dwell_cnt  = '0;
            w_next_disp_value = bus.req_data[DISP_W*w_grant +: DISP_W];
            w_next_disp_owner = w_grant;
            w_next_ack        = NUM_REQ'(1) << w_grant;
            w_next_rr_ptr     = (w_grant == LAST_IDX) ? '0 : w_grant + 1'b1;
        end
    end

    assign bus.ack        = r_ack;
    assign bus.disp_value = r_disp_value;
    assign bus.disp_owner = r_disp_owner;
    assign bus.busy       = (r_state == SHOW);
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter: vector table, corner sequences and a random
// run against a countdown-based model of the sharing rules.
module tb_display_share_arbiter;
    import display_pkg::*;

    localparam int NREQ  = 4;
    localparam int DWELL = 4;

    logic clk;
    logic rst;

    display_share_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    display_share_arbiter #(
        .NUM_REQ      (NREQ),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // model: m_left counts dwell cycles still owed to the current owner
    int          m_ptr   = 0;
    int          m_left  = 0;
    int          m_owner = 0;
    logic [15:0] m_disp  = '0;
    logic [3:0]  m_ack   = '0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        int          n_ptr, n_left, n_owner, win;
        logic [15:0] n_disp;
        logic [3:0]  n_ack;
        win = -1;
        if (rst) begin
            n_ptr = 0; n_left = 0; n_owner = 0; n_disp = '0; n_ack = '0;
            exp_q.delete();
        end else begin
            n_ptr = m_ptr; n_owner = m_owner; n_disp = m_disp; n_ack = '0;
            n_left = (m_left > 0) ? m_left - 1 : 0;
            if (m_left <= 1) begin
                for (int off = 0; off < NREQ; off++) begin
                    int idx;
                    idx = (m_ptr + off) % NREQ;
                    if (win < 0 && bus.req[idx]) win = idx;
                end
            end
            if (win >= 0) begin
                n_disp  = bus.req_data[16*win +: 16];
                n_owner = win;
                n_ack   = 4'(1) << win;
                n_ptr   = (win + 1) % NREQ;
                n_left  = DWELL;
                exp_q.push_back(n_disp);
            end
        end
        @(posedge clk);
        m_ptr = n_ptr; m_left = n_left; m_owner = n_owner; m_disp = n_disp; m_ack = n_ack;
        @(negedge clk);
        chk("model_ack", bus.ack, m_ack);
        chk("model_disp", bus.disp_value, m_disp);
        chk("model_owner", bus.disp_owner, m_owner);
        chk("model_busy", bus.busy, m_left > 0);
        chk("model_state", bus.dbg_state, (m_left > 0) ? SHOW : IDLE);
        if (bus.ack != '0) begin
            if (exp_q.size() == 0) chk("sb_unexpected_ack", bus.ack, 0);
            else chk("sb_value", bus.disp_value, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  ack;
        logic [15:0] disp;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] d_rr;
    logic [63:0] d_beef;
    logic [15:0] rr_vals[4];
    int          g_cnt;

    initial begin
        d_rr   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        d_beef = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        rr_vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        vecs[0]  = '{1'b1, 4'b1111, d_rr,   4'b0000, 16'h0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, d_rr,   4'b0000, 16'h0000, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, d_rr,   4'b0001, 16'h1111, 2'd0, 1'b1};
        vecs[3]  = '{1'b0, 4'b0000, d_rr,   4'b0000, 16'h1111, 2'd0, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, d_rr,   4'b0000, 16'h1111, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, 4'b0000, d_rr,   4'b0000, 16'h1111, 2'd0, 1'b1};
        vecs[6]  = '{1'b0, 4'b0100, d_beef, 4'b0100, 16'hBEEF, 2'd2, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, d_beef, 4'b0000, 16'hBEEF, 2'd2, 1'b1};
        vecs[8]  = '{1'b0, 4'b0000, d_beef, 4'b0000, 16'hBEEF, 2'd2, 1'b1};
        vecs[9]  = '{1'b0, 4'b0000, d_beef, 4'b0000, 16'hBEEF, 2'd2, 1'b1};
        vecs[10] = '{1'b0, 4'b0000, d_beef, 4'b0000, 16'hBEEF, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, d_beef, 4'b0000, 16'hBEEF, 2'd2, 1'b0};

        rst = 1'b1;
        bus.req = '0;
        bus.req_data = '0;

        // reset with demand, first grant, then a single request back-to-back
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            bus.req = vecs[i].req;
            bus.req_data = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_ack", i), bus.ack, vecs[i].ack);
            chk($sformatf("vec%0d_disp", i), bus.disp_value, vecs[i].disp);
            chk($sformatf("vec%0d_owner", i), bus.disp_owner, vecs[i].owner);
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
        end

        // round-robin under continuous demand
        do_reset();
        bus.req = 4'b1111;
        bus.req_data = d_rr;
        g_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c % DWELL == 0) begin
                chk("rr_ack", bus.ack, 4'(1) << (g_cnt % 4));
                chk("rr_disp", bus.disp_value, rr_vals[g_cnt % 4]);
                g_cnt++;
            end
        end
        chk("rr_grants", g_cnt, 5);

        // wrap and skip: grant 2, then 1001 -> 3 then 0
        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("wrap_first", bus.disp_owner, 2);
        bus.req = 4'b1001;
        repeat (4) tick();
        chk("wrap_to3_ack", bus.ack, 4'b1000);
        chk("wrap_to3_disp", bus.disp_value, 16'h4444);
        bus.req = 4'b0001;
        repeat (4) tick();
        chk("wrap_to0_ack", bus.ack, 4'b0001);
        chk("wrap_to0_owner", bus.disp_owner, 0);
        bus.req = '0;
        repeat (5) tick();

        // reset in the middle of a dwell
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0010;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_ack", bus.ack, 4'b0000);
        chk("midrst_disp", bus.disp_value, 16'h0000);
        rst = 1'b0;
        tick();
        chk("midrst_regrant_ack", bus.ack, 4'b0010);
        chk("midrst_regrant_disp", bus.disp_value, 16'h2222);
        bus.req = '0;
        repeat (5) tick();

        // withdrawn request during a dwell
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0010;
        repeat (2) tick();
        bus.req = 4'b0000;
        tick();
        chk("withdraw_busy", bus.busy, 1'b0);
        chk("withdraw_disp", bus.disp_value, 16'h1111);
        chk("withdraw_ack", bus.ack, 4'b0000);
        tick();

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.req = 4'($urandom_range(0, 15));
            bus.req_data = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0;
        bus.req = '0;
        repeat (6) tick();
        chk("sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/display_share_arbiter.md
Name: display_share_arbiter

Overview:
- Shares the single four-digit seven-segment display between NUM_REQ independent requesters.
- Each requester offers a 16-bit value (four hex nibbles, digit 3 = bits 15:12).
- The arbiter grants round-robin and holds the winner's value on the display for exactly DWELL_CYCLES clocks.
- disp_value connects directly to the 16-bit input of SevenSegFourDig, in place of a hand-written register in the top level.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DWELL_CYCLES, 100000000, clocks a granted value is guaranteed on display (1 s at 100 MHz); must be >= 1.
- CNT_W, 27, dwell counter width; must satisfy 2^CNT_W >= DWELL_CYCLES.
- OWN_W, $clog2(NUM_REQ), width of the owner index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester display request; level, held until ack.
- req_data  in  16*NUM_REQ  flattened values; requester i uses bits [16*i+15:16*i].
- ack  out  NUM_REQ  one-hot, one-cycle pulse when requester i's value is captured.
- disp_value  out  16  value driven to the seven-segment driver.
- disp_owner  out  OWN_W  index of the requester currently or last shown.
- busy  out  1  high while a dwell period is running.

Behaviour:
- All state changes occur on posedge clk. rst is synchronous, active-high, and has priority over everything else.
- Reset values:
  - disp_value = 16'h0000, disp_owner = 0, ack = 0, busy = 0.
  - rr_ptr = 0, dwell_cnt = 0, state = IDLE.
- States:
  - IDLE: no dwell running. busy = 0.
  - SHOW: dwell running. busy = 1.
- Pick function (combinational):
  - Returns the first i with req[i] = 1, searching rr_ptr, rr_ptr+1, ..., wrapping N-1 -> 0.
  - Returns "none" if req = 0.
- IDLE:
  - If pick = i in cycle T, then at the edge ending T:
    - disp_value <= req_data[i].
    - disp_owner <= i.
    - ack <= one-hot(i).
    - rr_ptr <= (i+1) mod NUM_REQ.
    - dwell_cnt <= 0.
    - state <= SHOW.
  - Otherwise all state is held.
- SHOW:
  - dwell_cnt increments each cycle.
  - When dwell_cnt == DWELL_CYCLES-1:
    - If pick = i, perform the same capture as in IDLE (back-to-back grant) and stay in SHOW.
    - Otherwise go to IDLE, with dwell_cnt <= 0.
- Timing guarantees:
  - Grant latency from IDLE is 1 cycle: req sampled in cycle T, ack and disp_value visible in cycle T+1.
  - Consecutive grants under continuous demand are spaced exactly DWELL_CYCLES cycles apart.
- Requests during SHOW (other than at the final count) are neither acknowledged nor lost. They are evaluated at dwell end.
- ack:
  - Registered, high for exactly one cycle per grant.
  - Cleared in every cycle without a capture.
- Display retention: disp_value and disp_owner hold the last captured value in IDLE. The display never blanks unless rst is asserted.
- Requester rules:
  - A requester may drop req before ack. The request is withdrawn, with no ack and no capture.
  - req_data[i] is sampled only in the capture cycle.
  - A requester must drop req the cycle after ack, or it re-enters arbitration at lowest priority (rr_ptr has moved past it).
- DWELL_CYCLES = 1: SHOW lasts one cycle; with continuous demand a new grant occurs every cycle.
- rr_ptr wrap-around: a grant to NUM_REQ-1 sets rr_ptr to 0.
- Reset mid-SHOW:
  - The dwell is abandoned and all registers return to reset values on that edge.
  - Pending requests are re-arbitrated from rr_ptr = 0 in the first cycle after rst deasserts.

Decomposition:
- Shared package display_pkg:
  - DISP_W = 16.
  - State enum {IDLE, SHOW}.
  - Default NUM_REQ and DWELL_CYCLES constants.
- One sub-module, display_rr_pick (purely combinational):
  - Inputs: req and rr_ptr.
  - Outputs: found and grant index.
  - Instantiated once.

Test Plan:
(All scenarios use NUM_REQ=4, DWELL_CYCLES=4.)
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> ack=0, busy=0, disp_value=16'h0000 throughout; first grant to requester 0 on the edge after rst falls.
2. Single request: req=4'b0100, data2=16'hBEEF in IDLE -> next cycle disp_value=BEEF, ack=4'b0100 for 1 cycle, disp_owner=2, busy=1 for 4 cycles; then busy=0 and disp_value stays BEEF.
3. Round-robin: req=4'b1111 held, data=1111/2222/3333/4444 -> disp_value sequence 1111,2222,3333,4444,1111; each value for exactly 4 cycles; ack pulses 0001,0010,0100,1000 at 4-cycle spacing.
4. Wrap and skip: after a grant to requester 2, apply req=4'b1001 -> grant 3 first, then 0 on the next dwell end.
5. Reset mid-SHOW: assert rst when dwell_cnt=2 -> next cycle disp_value=0, busy=0, ack=0; held req=4'b0010 is granted on the first edge after release.
6. Withdraw: req[1] pulsed high for 2 cycles during SHOW, low at dwell end -> no ack[1]; arbiter returns to IDLE with disp_value unchanged.
